// File: rtl/demux_bit_sequencer.sv
// demux_bit_sequencer: serializes one accepted byte into per-bit strobed slots for a 1:8 demux
module demux_bit_sequencer #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [7:0] s_data_i,
  output logic       dm_in_o,
  output logic [2:0] dm_sel_o,
  output logic       dm_strobe_o,
  output logic       busy_o,
  output logic       frame_done_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_t;
  localparam logic [2:0] FIRST   = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST    = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] GAP_END = 4'(GAP - 1);
  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic       dm_in_d, dm_strobe_d, busy_d, frame_done_d;
  logic [2:0] dm_sel_d;
  logic       dm_in_q, dm_strobe_q, busy_q, frame_done_q;
  logic [2:0] dm_sel_q;
  assign s_ready_o    = (state_q == IDLE) && rst_n;
  assign dm_in_o      = dm_in_q;
  assign dm_sel_o     = dm_sel_q;
  assign dm_strobe_o  = dm_strobe_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  // next state: capture on handshake, one SHIFT cycle per bit, GAP idle cycles between bits
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (s_valid_i && s_ready_o) begin
        state_d = SHIFT;
        sr_d    = s_data_i;
        idx_d   = FIRST;
      end
      SHIFT: if (idx_q == LAST) state_d = IDLE;
      else begin
        idx_d   = MSB_FIRST ? idx_q - 3'd1 : idx_q + 3'd1;
        state_d = (GAP > 0) ? WAIT : SHIFT;
        gap_d   = '0;
      end
      WAIT: if (gap_q == GAP_END) begin
        state_d = SHIFT;
        gap_d   = '0;
      end else gap_d = gap_q + 4'd1;
      default: state_d = IDLE;
    endcase
  end
  // outputs are derived from the next state so they register in step with it
  always_comb begin
    dm_strobe_d  = state_d == SHIFT;
    dm_sel_d     = dm_strobe_d ? idx_d : dm_sel_q;
    dm_in_d      = dm_strobe_d && sr_d[idx_d];
    busy_d       = state_d != IDLE;
    frame_done_d = dm_strobe_d && (idx_d == LAST);
  end
  // state and registered outputs; reset discards any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      dm_in_q      <= 1'b0;
      dm_sel_q     <= '0;
      dm_strobe_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      dm_in_q      <= dm_in_d;
      dm_sel_q     <= dm_sel_d;
      dm_strobe_q  <= dm_strobe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule

// File: tb/tb_demux_bit_sequencer.sv
// tb_demux_bit_sequencer: vector table, corner sequences and random traffic against a frame-timeline model
module tb_demux_bit_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] vld;
  logic [1:0][7:0] dat;
  logic [1:0] rdy, din, stb, bsy, fd;
  logic [1:0][2:0] sel;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gp[2] = '{0, 2};
  bit ms[2] = '{1'b0, 1'b1};
  bit act[2];
  bit acc[2];
  int pos[2];
  logic [7:0] byt[2];
  logic [2:0] lsel[2];

  always #5 clk = ~clk;

  demux_bit_sequencer #(.MSB_FIRST(1'b0), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid_i(vld[0]), .s_ready_o(rdy[0]), .s_data_i(dat[0]),
    .dm_in_o(din[0]), .dm_sel_o(sel[0]), .dm_strobe_o(stb[0]), .busy_o(bsy[0]), .frame_done_o(fd[0]));
  demux_bit_sequencer #(.MSB_FIRST(1'b1), .GAP(2)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid_i(vld[1]), .s_ready_o(rdy[1]), .s_data_i(dat[1]),
    .dm_in_o(din[1]), .dm_sel_o(sel[1]), .dm_strobe_o(stb[1]), .busy_o(bsy[1]), .frame_done_o(fd[1]));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // a frame is a timeline of 8+7*GAP cycles; a bit is emitted every GAP+1 cycles
  task automatic model_out(input int m, output logic s, output logic [2:0] sl, output logic i,
                           output logic f, output logic b, output logic r);
    int per, k, idx;
    per = gp[m] + 1;
    if (act[m]) begin
      k   = pos[m] / per;
      idx = ms[m] ? 7 - k : k;
      s   = (pos[m] % per) == 0;
      sl  = 3'(idx);
      i   = s & byt[m][idx];
      f   = pos[m] == 8 + 7 * gp[m] - 1;
      b   = 1'b1;
      r   = 1'b0;
    end else begin
      s = 1'b0; sl = lsel[m]; i = 1'b0; f = 1'b0; b = 1'b0; r = 1'b1;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      acc[m] = 1'b0;
      if (act[m]) begin
        pos[m]++;
        if (pos[m] == 8 + 7 * gp[m]) begin
          act[m]  = 1'b0;
          lsel[m] = ms[m] ? 3'd0 : 3'd7;
        end
      end else if (vld[m]) begin
        act[m] = 1'b1;
        pos[m] = 0;
        byt[m] = dat[m];
        acc[m] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; acc[m] = 1'b0; pos[m] = 0; lsel[m] = 3'd0;
    end
  endtask

  task automatic cmp_all();
    logic s, i, f, b, r;
    logic [2:0] sl;
    for (int m = 0; m < 2; m++) begin
      model_out(m, s, sl, i, f, b, r);
      chk($sformatf("u%0d.strobe", m), 32'(stb[m]), 32'(s));
      chk($sformatf("u%0d.sel", m), 32'(sel[m]), 32'(sl));
      chk($sformatf("u%0d.din", m), 32'(din[m]), 32'(i));
      chk($sformatf("u%0d.done", m), 32'(fd[m]), 32'(f));
      chk($sformatf("u%0d.busy", m), 32'(bsy[m]), 32'(b));
      chk($sformatf("u%0d.ready", m), 32'(rdy[m]), 32'(r));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    cmp_all();
    for (int m = 0; m < 2; m++) if (!vld[m]) dat[m] = 8'($urandom);
  endtask

  task automatic chk_zero(input string n, input logic r);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s.u%0d.ready", n, m), 32'(rdy[m]), 32'(r));
      chk($sformatf("%s.u%0d.outs", n, m), {27'd0, stb[m], sel[m], din[m], fd[m], bsy[m]}, 32'd0);
    end
  endtask

  // gathers the lane pattern of the frame under way, starting with the current cycle
  task automatic collect(input int m, output logic [7:0] rec, output int tdone);
    rec = '0;
    tdone = -1;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) step();
      if (stb[m]) rec[sel[m]] = din[m];
      if (fd[m]) begin
        tdone = cyc;
        break;
      end
    end
    chk($sformatf("u%0d.frame_timeout", m), 32'(tdone < 0), 32'd0);
  endtask

  typedef struct {
    logic v; logic [7:0] d;
    logic s; logic [2:0] sl; logic i; logic f; logic b; logic r;
  } vec_t;

  initial begin
    vec_t tbl[9];
    logic [7:0] a5, rec, rec2, lanes;
    int first, last, ns, t1, t2, td;
    a5 = 8'hA5;
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 1; k < 8; k++) tbl[k] = '{1'b0, 8'h00, 1'b1, 3'(k), a5[k], k == 7, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1};
    model_reset();
    vld = '0;
    dat = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vld = 2'($urandom);
      dat = 16'($urandom);
      #1 chk_zero("reset", 1'b0);
    end
    @(negedge clk);
    vld = '0;
    rst_n = 1'b1;
    #1 chk_zero("release", 1'b1);
    step();
    lanes = '0;
    for (int i = 0; i < 9; i++) begin
      vld[0] = tbl[i].v;
      if (tbl[i].v) dat[0] = tbl[i].d;
      step();
      vld[0] = 1'b0;
      chk($sformatf("tbl%0d.strobe", i), 32'(stb[0]), 32'(tbl[i].s));
      chk($sformatf("tbl%0d.sel", i), 32'(sel[0]), 32'(tbl[i].sl));
      chk($sformatf("tbl%0d.din", i), 32'(din[0]), 32'(tbl[i].i));
      chk($sformatf("tbl%0d.done", i), 32'(fd[0]), 32'(tbl[i].f));
      chk($sformatf("tbl%0d.busy", i), 32'(bsy[0]), 32'(tbl[i].b));
      chk($sformatf("tbl%0d.ready", i), 32'(rdy[0]), 32'(tbl[i].r));
      if (stb[0]) lanes[sel[0]] = din[0];
    end
    chk("lsb.lanes", 32'(lanes), 32'h000000A5);
    vld[1] = 1'b1;
    dat[1] = 8'h3C;
    step();
    vld[1] = 1'b0;
    first = -1;
    last = -1;
    ns = 0;
    rec = '0;
    for (int i = 0; i < 40 && last < 0; i++) begin
      if (i > 0) step();
      if (stb[1]) begin
        chk("msb.sel_order", 32'(sel[1]), 32'(7 - ns));
        rec[sel[1]] = din[1];
        if (first < 0) first = cyc;
        ns++;
      end
      if (fd[1]) last = cyc;
    end
    chk("msb.frame_len", 32'(last - first + 1), 32'd22);
    chk("msb.lanes", 32'(rec), 32'h0000003C);
    step();
    vld[0] = 1'b1;
    dat[0] = 8'hFF;
    step();
    dat[0] = 8'h00;
    collect(0, rec, t1);
    t2 = -1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (stb[0]) begin
        t2 = cyc;
        break;
      end
    end
    vld[0] = 1'b0;
    chk("b2b.gap", 32'(t2 - t1), 32'd2);
    collect(0, rec2, td);
    chk("b2b.first", 32'(rec), 32'h000000FF);
    chk("b2b.second", 32'(rec2), 32'h00000000);
    step();
    vld[0] = 1'b1;
    dat[0] = 8'h81;
    step();
    vld[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (stb[0] && sel[0] == 3'd3) break;
      step();
    end
    chk("midrst.reached_sel3", 32'(sel[0]), 32'd3);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst", 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_zero("midrst.release", 1'b1);
    vld[0] = 1'b1;
    dat[0] = 8'h7E;
    step();
    vld[0] = 1'b0;
    chk("midrst.restart_sel", 32'(sel[0]), 32'd0);
    collect(0, rec, td);
    chk("midrst.next_byte", 32'(rec), 32'h0000007E);
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (acc[m]) begin
          vld[m] = 1'($urandom % 2);
          dat[m] = 8'($urandom);
        end else if (!vld[m]) vld[m] = ($urandom % 3) == 0;
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
